// File: rtl/eth_arb_pkg.sv
// rtl/eth_arb_pkg.sv - shared types and constants for the ethernet RX port arbiter
//
// Purpose : arbiter FSM state type, default watchdog limit, stall-counter width
//           and the port-ID width helper used by the arbiter and its picker.
// Ports   : none (package).
// Config  : INPUTWIDTH supplies the default AXIS byte-lane width (8 if unset).

`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

package eth_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_META  = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 1024;
  localparam int STALL_W         = 16;

  // Port-ID width; a 2-port arbiter still needs one bit of ID.
  function automatic int port_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational round-robin requester picker
//
// Purpose : selects the first asserted request strictly after the pointer,
//           scanning ptr+1 .. ptr+NUM_PORTS modulo NUM_PORTS.
// Ports   : req    in  NUM_PORTS  request vector
//           ptr    in  PORT_W     last-served port
//           valid  out 1          some request is asserted
//           idx    out PORT_W     winning port index
//           onehot out NUM_PORTS  winning port as a one-hot vector

module eth_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic                 valid,
  output logic [PORT_W-1:0]    idx,
  output logic [NUM_PORTS-1:0] onehot
);

  logic [PORT_W-1:0] cand;

  // Scan from the farthest candidate back to the nearest so the last hit
  // written is the one closest after the pointer.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = PORT_W'((int'(ptr) + k) % NUM_PORTS);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

  assign onehot = valid ? (NUM_PORTS'(1) << idx) : '0;

endmodule

// File: rtl/ethernet_rx_port_arbiter.sv
// rtl/ethernet_rx_port_arbiter.sv - frame-granular round-robin arbiter for RX streams
//
// Purpose : shares one ethernet_ipv4_handler among NUM_PORTS byte-wide MAC RX
//           streams. One port owns the handler from its first byte until the
//           handler's metadata handshake (or drop strobe), and the owning port
//           ID is published alongside for the downstream TCP/UDP layers.
// Ports   : clk, rst_n                      clock, async active-low reset
//           s_axis_tdata/tvalid/tlast/tready per-port RX streams (port i data at
//                                            [i*DATA_WIDTH +: DATA_WIDTH])
//           m_axis_tdata/tvalid/tlast/tready stream to the handler
//           hdl_meta_valid, hdl_meta_ready   snooped handler metadata handshake
//           hdl_drop                         handler dropped the current frame
//           grant                            one-hot owner, 0 when idle
//           meta_port_id, meta_port_valid    owning port tag
//           abort                            one-cycle pulse on watchdog release
// Config  : ETH_ARB_TIMEOUT_EN enables the stall watchdog (TIMEOUT_CYCLES);
//           without it abort is held low.

`ifndef INPUTWIDTH
`define INPUTWIDTH 8
`endif

module ethernet_rx_port_arbiter
  import eth_arb_pkg::*;
#(
  parameter  int NUM_PORTS      = 4,
  parameter  int DATA_WIDTH     = `INPUTWIDTH,
  parameter  int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  localparam int PORT_W         = port_w(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  input  logic                            hdl_meta_valid,
  input  logic                            hdl_meta_ready,
  input  logic                            hdl_drop,
  output logic [NUM_PORTS-1:0]            grant,
  output logic [PORT_W-1:0]               meta_port_id,
  output logic                            meta_port_valid,
  output logic                            abort
);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PORT_W-1:0]    port_q, port_d;
  logic [PORT_W-1:0]    ptr_q, ptr_d;
  logic                 meta_valid_q, meta_valid_d;
  logic                 abort_q, abort_d;

  logic                 pick_valid;
  logic [PORT_W-1:0]    pick_idx;
  logic [NUM_PORTS-1:0] pick_onehot;

  logic                  in_frame;
  logic                  g_tvalid;
  logic                  g_tlast;
  logic [DATA_WIDTH-1:0] g_tdata;
  logic                  beat;
  logic                  meta_done;
  logic                  stall_expire;
  logic                  release_port;

  // Arbitration only matters in S_IDLE; the result is ignored elsewhere.
  eth_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .req    (s_axis_tvalid),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Granted port's stream, selected by the registered port ID.
  assign in_frame  = (state_q == S_FRAME);
  assign g_tvalid  = s_axis_tvalid[port_q];
  assign g_tlast   = s_axis_tlast[port_q];
  assign g_tdata   = s_axis_tdata[int'(port_q)*DATA_WIDTH +: DATA_WIDTH];
  assign beat      = in_frame && g_tvalid && m_axis_tready;
  assign meta_done = (hdl_meta_valid && hdl_meta_ready) || hdl_drop;

  // Zero-latency pass-through; forced to zero outside S_FRAME so the handler
  // never sees a stray beat while waiting on metadata.
  assign m_axis_tvalid = in_frame && g_tvalid;
  assign m_axis_tlast  = in_frame && g_tlast;
  assign m_axis_tdata  = in_frame ? g_tdata : '0;
  assign s_axis_tready = (in_frame && m_axis_tready) ? grant_q : '0;

`ifdef ETH_ARB_TIMEOUT_EN
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               stall_tick;

  // A stall is a granted source going quiet mid-frame, or any cycle spent
  // waiting for the metadata handshake.
  assign stall_tick   = (in_frame && !g_tvalid) || (state_q == S_META);
  // A metadata handshake landing on the limit cycle still completes normally.
  assign stall_expire = stall_tick && (stall_q == STALL_LAST) &&
                        !((state_q == S_META) && meta_done);

  always_comb begin
    stall_d = stall_q;
    if (beat || (state_d != state_q)) begin
      stall_d = '0;
    end else if (stall_tick) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout;

  assign stall_expire   = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    port_d       = port_q;
    ptr_d        = ptr_q;
    meta_valid_d = meta_valid_q;
    abort_d      = 1'b0;
    release_port = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d      = S_FRAME;
          grant_d      = pick_onehot;
          port_d       = pick_idx;
          meta_valid_d = 1'b1;
        end
      end
      S_FRAME: begin
        // Metadata strobes here belong to no frame of ours and are ignored.
        if (beat && g_tlast) begin
          state_d = S_META;
        end
      end
      S_META: begin
        release_port = meta_done;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stall_expire) begin
      release_port = 1'b1;
      abort_d      = 1'b1;
    end

    // The released port becomes the pointer so it drops to lowest priority.
    if (release_port) begin
      state_d      = S_IDLE;
      grant_d      = '0;
      ptr_d        = port_q;
      meta_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      port_q       <= '0;
      ptr_q        <= PORT_W'(NUM_PORTS - 1);
      meta_valid_q <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      port_q       <= port_d;
      ptr_q        <= ptr_d;
      meta_valid_q <= meta_valid_d;
      abort_q      <= abort_d;
    end
  end

  assign grant           = grant_q;
  assign meta_port_id    = port_q;
  assign meta_port_valid = meta_valid_q;
  assign abort           = abort_q;

endmodule

// File: tb/tb_ethernet_rx_port_arbiter.sv
// tb/tb_ethernet_rx_port_arbiter.sv - self-checking bench for ethernet_rx_port_arbiter

module tb_ethernet_rx_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]   s_tvalid;
  logic [NP-1:0]   s_tready;
  logic [NP-1:0]   s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic            hdl_meta_valid;
  logic            hdl_meta_ready;
  logic            hdl_drop;
  logic [NP-1:0]   grant;
  logic [1:0]      meta_port_id;
  logic            meta_port_valid;
  logic            abort;

  always #5 clk = ~clk;

  ethernet_rx_port_arbiter #(
    .NUM_PORTS      (NP),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .s_axis_tlast    (s_tlast),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .m_axis_tlast    (m_tlast),
    .hdl_meta_valid  (hdl_meta_valid),
    .hdl_meta_ready  (hdl_meta_ready),
    .hdl_drop        (hdl_drop),
    .grant           (grant),
    .meta_port_id    (meta_port_id),
    .meta_port_valid (meta_port_valid),
    .abort           (abort)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-port frame byte queues {last, data}, the owning
  // port (-1 when nobody owns the handler), whether the owner has finished
  // its bytes and awaits metadata, and the last-served port.
  logic [8:0] src_q[NP][$];
  int  m_port;
  bit  m_meta;
  int  m_ptr;
  int  meta_wait;
  int  grant_log[$];
  int  bytes_fwd;
  int  rdy_low;
  int  tready_pct;
  int  low_from;
  int  low_len;
  bit  use_drop;
  bit  noise;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_next(input int ptr, input logic [NP-1:0] mask);
    for (int k = 1; k <= NP; k++) begin
      if (mask[(ptr + k) % NP]) return (ptr + k) % NP;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NP-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NP; i++) begin
      if (v[i]) r = (r == -1) ? i : -2;
    end
    return r;
  endfunction

  function automatic bit pending();
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic load_frame(input int p, input int len);
    for (int i = 0; i < len; i++) begin
      src_q[p].push_back({(i == len - 1), 8'($urandom)});
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_grant"},  32'(grant), 0);
    chk({tag, "_tready"}, 32'(s_tready), 0);
    chk({tag, "_mvalid"}, 32'(m_tvalid), 0);
    chk({tag, "_mlast"},  32'(m_tlast), 0);
    chk({tag, "_mdata"},  32'(m_tdata), 0);
    chk({tag, "_pid"},    32'(meta_port_id), 0);
    chk({tag, "_pvalid"}, 32'(meta_port_valid), 0);
    chk({tag, "_abort"},  32'(abort), 0);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    s_tvalid       = '0;
    s_tlast        = '0;
    s_tdata        = '0;
    m_tready       = 1'b0;
    hdl_meta_valid = 1'b0;
    hdl_meta_ready = 1'b0;
    hdl_drop       = 1'b0;
    step();
    step();
    check_reset_values("reset");
    rst_n  = 1'b1;
    m_port = -1;
    m_meta = 1'b0;
    m_ptr  = NP - 1;
    grant_log.delete();
  endtask

  // Drives every port as an AXIS source from its queue, plays the handler,
  // and compares the DUT against the model every cycle.
  task automatic run_traffic(input int budget);
    int cycles;
    bit started, hv, hr, drp;
    logic [NP-1:0] mask;
    cycles    = 0;
    bytes_fwd = 0;
    rdy_low   = 0;
    while ((pending() || m_port >= 0) && cycles < budget) begin
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0) begin
          s_tvalid[p]          = 1'b1;
          s_tdata[p*DW +: DW]  = src_q[p][0][7:0];
          s_tlast[p]           = src_q[p][0][8];
        end else begin
          s_tvalid[p]          = 1'b0;
          s_tdata[p*DW +: DW]  = 8'($urandom);
          s_tlast[p]           = 1'($urandom);
        end
      end
      if (cycles >= low_from && cycles < low_from + low_len) m_tready = 1'b0;
      else m_tready = ($urandom_range(99) < tready_pct);

      hv = 1'b0; hr = 1'b0; drp = 1'b0;
      if (m_meta) begin
        if (meta_wait >= 3 || $urandom_range(1) == 1) begin
          if (use_drop) drp = 1'b1;
          else begin hv = 1'b1; hr = 1'b1; end
        end else begin
          hv = 1'($urandom_range(1));
        end
      end else if (noise) begin
        drp = ($urandom_range(3) == 0);
        hv  = 1'($urandom_range(1));
        hr  = 1'($urandom_range(1));
      end
      hdl_meta_valid = hv;
      hdl_meta_ready = hr;
      hdl_drop       = drp;
      #1;

      chk("abort_quiet", 32'(abort), 0);
      if (m_port < 0) begin
        chk("idle_grant",  32'(grant), 0);
        chk("idle_tready", 32'(s_tready), 0);
        chk("idle_mvalid", 32'(m_tvalid), 0);
        chk("idle_pvalid", 32'(meta_port_valid), 0);
      end else if (!m_meta) begin
        chk("frame_grant",  32'(grant), 32'(1 << m_port));
        chk("frame_pid",    32'(meta_port_id), 32'(m_port));
        chk("frame_pvalid", 32'(meta_port_valid), 1);
        chk("frame_tready", 32'(s_tready), m_tready ? 32'(1 << m_port) : 0);
        chk("frame_mvalid", 32'(m_tvalid), 32'(src_q[m_port].size() > 0));
        if (src_q[m_port].size() > 0) begin
          chk("frame_data", 32'(m_tdata), 32'(src_q[m_port][0][7:0]));
          chk("frame_last", 32'(m_tlast), 32'(src_q[m_port][0][8]));
        end
        if (s_tready[m_port] == 1'b0) rdy_low++;
      end else begin
        chk("meta_grant",  32'(grant), 32'(1 << m_port));
        chk("meta_pid",    32'(meta_port_id), 32'(m_port));
        chk("meta_pvalid", 32'(meta_port_valid), 1);
        chk("meta_tready", 32'(s_tready), 0);
        chk("meta_mvalid", 32'(m_tvalid), 0);
      end

      started = 1'b0;
      if (m_port < 0) begin
        for (int p = 0; p < NP; p++) mask[p] = (src_q[p].size() > 0);
        if (mask != '0) begin
          m_port  = rr_next(m_ptr, mask);
          started = 1'b1;
        end
      end else if (!m_meta) begin
        if (m_tready && src_q[m_port].size() > 0) begin
          bytes_fwd++;
          if (src_q[m_port][0][8]) begin
            m_meta    = 1'b1;
            meta_wait = 0;
          end
          void'(src_q[m_port].pop_front());
        end
      end else begin
        if (drp || (hv && hr)) begin
          m_ptr  = m_port;
          m_port = -1;
          m_meta = 1'b0;
        end else begin
          meta_wait++;
        end
      end

      step();
      if (started) grant_log.push_back(onehot_idx(grant));
      cycles++;
    end
    chk("run_within_budget", 32'(cycles < budget), 1);
    s_tvalid       = '0;
    m_tready       = 1'b0;
    hdl_meta_valid = 1'b0;
    hdl_meta_ready = 1'b0;
    hdl_drop       = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    tready_pct = 100;
    low_from   = 0;
    low_len    = 0;
    use_drop   = 1'b0;
    noise      = 1'b0;

    // Single 60-byte frame from port 2.
    do_reset();
    load_frame(2, 60);
    run_traffic(400);
    chk("t1_grant_port", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 2);
    chk("t1_bytes", 32'(bytes_fwd), 60);

    // Ports 0,1,3 contend from a fresh pointer.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      load_frame(0, $urandom_range(1, 12));
      load_frame(1, $urandom_range(1, 12));
      load_frame(3, $urandom_range(1, 12));
    end
    tready_pct = 70;
    run_traffic(1000);
    chk("t2_order0", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 0);
    chk("t2_order1", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 1);
    chk("t2_order2", 32'(grant_log.size() > 2 ? grant_log[2] : -1), 3);
    chk("t2_order3", 32'(grant_log.size() > 3 ? grant_log[3] : -1), 0);
    chk("t2_frames", 32'(grant_log.size()), 6);

    // Handler backpressure for 5 cycles mid-frame.
    grant_log.delete();
    load_frame(0, 30);
    tready_pct = 100;
    low_from   = 10;
    low_len    = 5;
    run_traffic(400);
    low_len = 0;
    chk("t3_bytes", 32'(bytes_fwd), 30);
    chk("t3_ready_low", 32'(rdy_low), 5);

    // Frames closed by the drop strobe instead of a metadata handshake.
    grant_log.delete();
    load_frame(1, $urandom_range(2, 20));
    load_frame(2, $urandom_range(2, 20));
    use_drop = 1'b1;
    run_traffic(400);
    use_drop = 1'b0;
    chk("t4_frames", 32'(grant_log.size()), 2);

    // Random multi-port traffic with stray metadata strobes outside S_META.
    grant_log.delete();
    for (int r = 0; r < 14; r++) load_frame($urandom_range(NP - 1), $urandom_range(1, 16));
    noise      = 1'b1;
    tready_pct = 60;
    run_traffic(3000);
    noise = 1'b0;
    chk("t7_frames", 32'(grant_log.size()), 14);

    // Granted source stalls after 10 bytes while port 1 waits.
    do_reset();
    m_tready          = 1'b1;
    s_tvalid          = 4'b0011;
    s_tlast           = 4'b0010;
    s_tdata[8 +: 8]   = 8'hA5;
    s_tdata[7:0]      = 8'h00;
    step();
    chk("t5_grant0", 32'(grant), 1);
    for (int i = 0; i < 10; i++) begin
      s_tdata[7:0] = 8'(8'h10 + i);
      #1;
      chk("t5_mvalid", 32'(m_tvalid), 1);
      chk("t5_byte", 32'(m_tdata), 32'(8'h10 + i));
      step();
    end
    s_tvalid[0] = 1'b0;
    #1;
    chk("t5_abort_start", 32'(abort), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
`ifdef ETH_ARB_TIMEOUT_EN
      chk("t5_abort", 32'(abort), 32'(k == 16));
`else
      chk("t5_abort", 32'(abort), 0);
`endif
    end
`ifdef ETH_ARB_TIMEOUT_EN
    chk("t5_idle_grant", 32'(grant), 0);
    chk("t5_idle_pvalid", 32'(meta_port_valid), 0);
    step();
    chk("t5_next_grant", 32'(grant), 32'(4'b0010));
    chk("t5_abort_pulse", 32'(abort), 0);
`else
    chk("t5_hold_grant", 32'(grant), 1);
    chk("t5_hold_pvalid", 32'(meta_port_valid), 1);
`endif

    // Reset in the middle of a port-1 frame.
    do_reset();
    m_tready = 1'b1;
    s_tvalid = 4'b0010;
    s_tlast  = '0;
    s_tdata  = 32'h5A5A5A5A;
    step();
    chk("t6_grant1", 32'(grant), 32'(4'b0010));
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    s_tvalid = 4'b0011;
    step();
    chk("t6_port0_first", 32'(grant), 1);
    chk("t6_pid", 32'(meta_port_id), 0);
    s_tvalid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
